// File: rtl/mc_sequencer.sv
// Multicycle control sequencer: drives datapath selects/enables per state.
// Optional MC_SEQ_IRQ_EN adds interrupt entry via IRQ_SAVE and IRQ_VEC.
module mc_sequencer #(
    parameter int WAIT_CYCLES = 8388607,
    parameter int WAIT_W      = 24,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] op,
    input  logic [3:0] op_ext,
    input  logic       branch_taken,
    input  logic       mem_ready,
    input  logic       irq,
    output logic [1:0] wd_s,
    output logic [1:0] alua_s,
    output logic [1:0] alub_s,
    output logic [1:0] mem_s,
    output logic       mem_data_s,
    output logic       pc_s,
    output logic       pc_en,
    output logic       reg_wr_en,
    output logic       instr_en,
    output logic       alu_out_en,
    output logic       mem_reg_en,
    output logic       mem_wr,
    output logic       se_sign,
    output logic       psr_en,
    output logic       mem_req,
    output logic       fault,
    output logic       irq_ack,
    output logic       epc_en,
    output logic       vec_s,
    output logic [4:0] state_o
);

    localparam int ST_W = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);

    typedef enum logic [4:0] {
        S_FETCH      = 5'd0,
        S_DECODE     = 5'd1,
        S_RTYPE_EX   = 5'd2,
        S_ITYPE_EX   = 5'd3,
        S_WRITE      = 5'd4,
        S_LB_MEM     = 5'd5,
        S_LB_LOAD    = 5'd6,
        S_SB_MEM_R   = 5'd7,
        S_SB_MEM_I   = 5'd8,
        S_CALC_DISP  = 5'd9,
        S_JUMP       = 5'd10,
        S_CALC_RLINK = 5'd11,
        S_WR_RLINK_J = 5'd12,
        S_PC_UP      = 5'd13,
        S_WAIT       = 5'd14,
        S_FAULT      = 5'd15,
        S_IRQ_SAVE   = 5'd16,
        S_IRQ_VEC    = 5'd17
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [WAIT_W-1:0] r_wait;
    logic [ST_W-1:0]   r_stall;
    logic [ST_W-1:0]   w_stall_inc;
    logic              w_mem_req;
    logic              w_instr_en;
    logic              w_stall;
    logic              w_timeout;
    logic              w_wait_done;

`ifndef MC_SEQ_IRQ_EN
    logic w_unused_irq;
    assign w_unused_irq = irq;
`endif

    // A stalled cycle is a pending access without mem_ready; the timeout
    // fires on the cycle that is the MEM_TIMEOUT-th consecutive stall.
    assign w_stall     = w_mem_req & ~mem_ready;
    assign w_stall_inc = r_stall + ST_W'(1);
    assign w_timeout   = (MEM_TIMEOUT != 0) && w_stall &&
                         (w_stall_inc == ST_W'(MEM_TIMEOUT));
    assign w_wait_done = (r_wait == WAIT_W'(WAIT_CYCLES - 1));
    assign state_o     = r_state;
    assign mem_req     = w_mem_req & ~reset;
    assign instr_en    = w_instr_en & ~reset;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    // WAIT counter: runs only while in WAIT, cleared everywhere else
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wait <= '0;
        end else if (r_state == S_WAIT) begin
            r_wait <= r_wait + WAIT_W'(1);
        end else begin
            r_wait <= '0;
        end
    end

    // Stall counter: consecutive memory cycles without mem_ready (saturating)
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stall <= '0;
        end else if (w_stall) begin
            if (r_stall != '1) begin
                r_stall <= w_stall_inc;
            end
        end else begin
            r_stall <= '0;
        end
    end

    // Next-state decode
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_FETCH:      if (mem_ready) w_next = S_DECODE;
            S_DECODE: begin
                if (op == 4'b0100) begin
                    if (op_ext == 4'b0100)      w_next = S_SB_MEM_R;
                    else if (op_ext == 4'b0000) w_next = S_LB_MEM;
                    else if (op_ext == 4'b1100)
                        w_next = branch_taken ? S_JUMP : S_PC_UP;
                    else if (op_ext == 4'b1000) w_next = S_CALC_RLINK;
                    else                        w_next = S_FAULT;
                end else if (op == 4'b0000) begin
                    w_next = S_RTYPE_EX;
                end else if (op == 4'b1000) begin
                    w_next = (op_ext == 4'b0100) ? S_RTYPE_EX : S_ITYPE_EX;
                end else if (op == 4'b1100) begin
                    w_next = branch_taken ? S_CALC_DISP : S_PC_UP;
                end else begin
                    w_next = S_ITYPE_EX;
                end
            end
            S_RTYPE_EX: begin
                if (op_ext == 4'b1011)      w_next = S_PC_UP;
                else if (op_ext == 4'b0000) w_next = S_WAIT;
                else                        w_next = S_WRITE;
            end
            S_ITYPE_EX: begin
                if (op == 4'b1011)      w_next = S_PC_UP;
                else if (op == 4'b0111) w_next = S_SB_MEM_I;
                else                    w_next = S_WRITE;
            end
            S_WRITE:      w_next = S_PC_UP;
            S_LB_MEM:     if (mem_ready) w_next = S_LB_LOAD;
            S_LB_LOAD:    w_next = S_PC_UP;
            S_SB_MEM_R:   if (mem_ready) w_next = S_PC_UP;
            S_SB_MEM_I:   if (mem_ready) w_next = S_PC_UP;
            S_CALC_DISP:  w_next = S_FETCH;
            S_JUMP:       w_next = S_FETCH;
            S_CALC_RLINK: w_next = S_WR_RLINK_J;
            S_WR_RLINK_J: w_next = S_FETCH;
`ifdef MC_SEQ_IRQ_EN
            S_PC_UP:      w_next = irq ? S_IRQ_SAVE : S_FETCH;
            S_IRQ_SAVE:   w_next = S_IRQ_VEC;
`else
            S_PC_UP:      w_next = S_FETCH;
            S_IRQ_SAVE:   w_next = S_FETCH;
`endif
            S_IRQ_VEC:    w_next = S_FETCH;
            S_WAIT:       if (w_wait_done) w_next = S_PC_UP;
            S_FAULT:      w_next = S_FAULT;
            default:      w_next = S_FAULT;
        endcase
        if (w_timeout) begin
            w_next = S_FAULT;
        end
    end

    // Output decode from the current state (mem_ready gates two enables)
    always_comb begin
        wd_s       = 2'b00;
        alua_s     = 2'b00;
        alub_s     = 2'b00;
        mem_s      = 2'b00;
        mem_data_s = 1'b0;
        pc_s       = 1'b0;
        pc_en      = 1'b0;
        reg_wr_en  = 1'b0;
        w_instr_en = 1'b0;
        alu_out_en = 1'b0;
        mem_reg_en = 1'b0;
        mem_wr     = 1'b0;
        se_sign    = 1'b1;
        psr_en     = 1'b0;
        w_mem_req  = 1'b0;
        fault      = 1'b0;
        irq_ack    = 1'b0;
        epc_en     = 1'b0;
        vec_s      = 1'b0;
        unique case (r_state)
            S_FETCH: begin
                mem_s      = 2'b01;
                w_mem_req  = 1'b1;
                w_instr_en = mem_ready;
            end
            S_RTYPE_EX: begin
                alu_out_en = 1'b1;
                psr_en     = 1'b1;
            end
            S_ITYPE_EX: begin
                alua_s     = 2'b10;
                alu_out_en = 1'b1;
                psr_en     = 1'b1;
                if (op == 4'b0001 || op == 4'b0010 || op == 4'b0011)
                    se_sign = 1'b0;
            end
            S_WRITE: begin
                wd_s      = 2'b11;
                reg_wr_en = 1'b1;
            end
            S_LB_MEM: begin
                wd_s       = 2'b10;
                w_mem_req  = 1'b1;
                mem_reg_en = mem_ready;
            end
            S_LB_LOAD: begin
                wd_s      = 2'b10;
                reg_wr_en = 1'b1;
            end
            S_SB_MEM_R: begin
                mem_wr    = 1'b1;
                w_mem_req = 1'b1;
            end
            S_SB_MEM_I: begin
                mem_s      = 2'b10;
                mem_wr     = 1'b1;
                mem_data_s = 1'b1;
                w_mem_req  = 1'b1;
            end
            S_CALC_DISP: begin
                alua_s = 2'b01;
                alub_s = 2'b01;
                pc_s   = 1'b1;
                pc_en  = 1'b1;
            end
            S_JUMP: pc_en = 1'b1;
            S_CALC_RLINK: begin
                alua_s     = 2'b01;
                alub_s     = 2'b10;
                alu_out_en = 1'b1;
            end
            S_WR_RLINK_J: begin
                wd_s      = 2'b11;
                reg_wr_en = 1'b1;
                pc_en     = 1'b1;
            end
            S_PC_UP: begin
                alua_s = 2'b01;
                alub_s = 2'b10;
                pc_s   = 1'b1;
                pc_en  = 1'b1;
            end
            S_FAULT: begin
                fault   = 1'b1;
                se_sign = 1'b0;
            end
`ifdef MC_SEQ_IRQ_EN
            S_IRQ_SAVE: begin
                epc_en  = 1'b1;
                irq_ack = 1'b1;
            end
            S_IRQ_VEC: begin
                vec_s = 1'b1;
                pc_en = 1'b1;
            end
`endif
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mc_sequencer.sv
// Bench for mc_sequencer: behavioural model checked every cycle plus
// directed instruction sequences with literal state traces.
module tb_mc_sequencer;

    localparam int WC = 5;
    localparam int MT = 4;

    localparam logic [4:0] S_FETCH = 5'd0,  S_DECODE = 5'd1,
        S_RTYPE = 5'd2,  S_ITYPE = 5'd3,  S_WRITE = 5'd4,
        S_LBM = 5'd5,    S_LBL = 5'd6,    S_SBR = 5'd7,
        S_SBI = 5'd8,    S_CD = 5'd9,     S_JUMP = 5'd10,
        S_CR = 5'd11,    S_WRJ = 5'd12,   S_PCUP = 5'd13,
        S_WAIT = 5'd14,  S_FAULT = 5'd15, S_ISAVE = 5'd16,
        S_IVEC = 5'd17;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [3:0] op = 4'd0;
    logic [3:0] op_ext = 4'd0;
    logic branch_taken = 1'b0;
    logic mem_ready = 1'b0;
    logic irq = 1'b0;
    logic [1:0] wd_s, alua_s, alub_s, mem_s;
    logic mem_data_s, pc_s, pc_en, reg_wr_en, instr_en, alu_out_en;
    logic mem_reg_en, mem_wr, se_sign, psr_en, mem_req, fault;
    logic irq_ack, epc_en, vec_s;
    logic [4:0] state_o;

    mc_sequencer #(.WAIT_CYCLES(WC), .WAIT_W(4), .MEM_TIMEOUT(MT)) dut (
        .clk(clk), .reset(reset), .op(op), .op_ext(op_ext),
        .branch_taken(branch_taken), .mem_ready(mem_ready), .irq(irq),
        .wd_s(wd_s), .alua_s(alua_s), .alub_s(alub_s), .mem_s(mem_s),
        .mem_data_s(mem_data_s), .pc_s(pc_s), .pc_en(pc_en),
        .reg_wr_en(reg_wr_en), .instr_en(instr_en),
        .alu_out_en(alu_out_en), .mem_reg_en(mem_reg_en),
        .mem_wr(mem_wr), .se_sign(se_sign), .psr_en(psr_en),
        .mem_req(mem_req), .fault(fault), .irq_ack(irq_ack),
        .epc_en(epc_en), .vec_s(vec_s), .state_o(state_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    logic [4:0] m_state = S_FETCH;
    int m_wait = 0;
    int m_stall = 0;
    logic [4:0] tr_st[$];
    bit tr_wr[$];
    bit tr_mre[$];
    logic [4:0] want[$];

    wire [27:0] got = {wd_s, alua_s, alub_s, mem_s, mem_data_s, pc_s,
        pc_en, reg_wr_en, instr_en, alu_out_en, mem_reg_en, mem_wr,
        se_sign, psr_en, mem_req, fault, irq_ack, epc_en, vec_s, state_o};

    function automatic logic [27:0] model_out(logic [4:0] s, logic rst,
                                              logic [3:0] o, logic mr);
        logic [1:0] wd = 0, aa = 0, ab = 0, ms = 0;
        logic mds = 0, pcs = 0, pce = 0, rwe = 0, ien = 0, aoe = 0;
        logic mre = 0, mwr = 0, se = 1, psr = 0, req = 0, flt = 0;
        logic ack = 0, epc = 0, vec = 0;
        logic [4:0] st = s;
        if (rst) begin
            ms = 2'b01;
            st = S_FETCH;
        end else begin
            case (s)
                S_FETCH: begin ms = 1; req = 1; ien = mr; end
                S_RTYPE: begin aoe = 1; psr = 1; end
                S_ITYPE: begin
                    aa = 2; aoe = 1; psr = 1;
                    if (o == 1 || o == 2 || o == 3) se = 0;
                end
                S_WRITE: begin wd = 3; rwe = 1; end
                S_LBM:   begin wd = 2; req = 1; mre = mr; end
                S_LBL:   begin wd = 2; rwe = 1; end
                S_SBR:   begin mwr = 1; req = 1; end
                S_SBI:   begin ms = 2; mwr = 1; mds = 1; req = 1; end
                S_CD:    begin aa = 1; ab = 1; pcs = 1; pce = 1; end
                S_JUMP:  pce = 1;
                S_CR:    begin aa = 1; ab = 2; aoe = 1; end
                S_WRJ:   begin wd = 3; rwe = 1; pce = 1; end
                S_PCUP:  begin aa = 1; ab = 2; pcs = 1; pce = 1; end
                S_FAULT: begin flt = 1; se = 0; end
`ifdef MC_SEQ_IRQ_EN
                S_ISAVE: begin epc = 1; ack = 1; end
                S_IVEC:  begin vec = 1; pce = 1; end
`endif
                default: ;
            endcase
        end
        return {wd, aa, ab, ms, mds, pcs, pce, rwe, ien, aoe, mre, mwr,
                se, psr, req, flt, ack, epc, vec, st};
    endfunction

    function automatic logic [4:0] model_next(logic [4:0] s,
        logic [3:0] o, logic [3:0] e, logic b, logic mr, logic iq);
        case (s)
            S_FETCH: return mr ? S_DECODE : S_FETCH;
            S_DECODE: begin
                if (o == 4) begin
                    if (e == 4) return S_SBR;
                    if (e == 0) return S_LBM;
                    if (e == 12) return b ? S_JUMP : S_PCUP;
                    if (e == 8) return S_CR;
                    return S_FAULT;
                end
                if (o == 0) return S_RTYPE;
                if (o == 8) return (e == 4) ? S_RTYPE : S_ITYPE;
                if (o == 12) return b ? S_CD : S_PCUP;
                return S_ITYPE;
            end
            S_RTYPE: return (e == 11) ? S_PCUP : (e == 0) ? S_WAIT : S_WRITE;
            S_ITYPE: return (o == 11) ? S_PCUP : (o == 7) ? S_SBI : S_WRITE;
            S_WRITE, S_LBL: return S_PCUP;
            S_LBM: return mr ? S_LBL : S_LBM;
            S_SBR, S_SBI: return mr ? S_PCUP : s;
            S_CD, S_JUMP, S_WRJ, S_IVEC: return S_FETCH;
            S_CR: return S_WRJ;
`ifdef MC_SEQ_IRQ_EN
            S_PCUP: return iq ? S_ISAVE : S_FETCH;
`else
            S_PCUP: return iq ? S_FETCH : S_FETCH;
`endif
            S_ISAVE: return S_IVEC;
            S_WAIT: return S_WAIT;
            default: return S_FAULT;
        endcase
    endfunction

    // Compare process: check at negedge, advance model at posedge
    always begin
        logic [27:0] exp_v;
        logic [4:0] nxt;
        @(negedge clk);
        if (reset) begin
            m_state = S_FETCH;
            m_wait = 0;
            m_stall = 0;
        end
        exp_v = model_out(m_state, reset, op, mem_ready);
        checks++;
        if (got !== exp_v) begin
            failures++;
            $display("FAIL outputs t=%0t got=%h want=%h", $time, got, exp_v);
        end
        if (!reset) begin
            tr_st.push_back(state_o);
            tr_wr.push_back(reg_wr_en);
            tr_mre.push_back(mem_reg_en);
        end
        @(posedge clk);
        if (!reset) begin
            nxt = model_next(m_state, op, op_ext, branch_taken, mem_ready, irq);
            if (m_state == S_WAIT) begin
                m_wait++;
                if (m_wait == WC) nxt = S_PCUP;
            end else begin
                m_wait = 0;
            end
            if ((m_state == S_FETCH || m_state == S_LBM || m_state == S_SBR ||
                 m_state == S_SBI) && !mem_ready) begin
                m_stall++;
                if (MT != 0 && m_stall == MT) nxt = S_FAULT;
            end else begin
                m_stall = 0;
            end
            m_state = nxt;
        end
    end

    task automatic chk(input string nm, input int g, input int w);
        checks++;
        if (g !== w) begin
            failures++;
            $display("FAIL %s got=%0d want=%0d", nm, g, w);
        end
    endtask

    task automatic chk_trace(input string nm);
        bit ok = (tr_st.size() == want.size());
        if (ok) foreach (want[i]) if (tr_st[i] !== want[i]) ok = 0;
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s got=%p want=%p", nm, tr_st, want);
        end
    endtask

    task automatic chk_bits(input string nm, input bit q[$], input int w);
        int v = 0;
        foreach (q[i]) if (q[i]) v = v | (1 << i);
        chk(nm, v, w);
    endtask

    task automatic clr();
        tr_st.delete();
        tr_wr.delete();
        tr_mre.delete();
    endtask

    task automatic cyc(input logic [3:0] o, input logic [3:0] e,
                       input logic b, input logic mr, input logic iq);
        op = o; op_ext = e; branch_taken = b; mem_ready = mr; irq = iq;
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n, input logic [3:0] o, input logic [3:0] e,
                       input logic b, input logic mr, input logic iq);
        for (int i = 0; i < n; i++) cyc(o, e, b, mr, iq);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        run(2, 0, 0, 0, 0, 0);
        reset = 1'b0;
        clr();
    endtask

    initial begin
        mem_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_state", int'(state_o), 0);
        chk("rst_mem_s", int'(mem_s), 1);
        chk("rst_se", int'(se_sign), 1);
        chk("rst_req", int'(mem_req), 0);
        chk("rst_ien", int'(instr_en), 0);
        reset = 1'b0;
        clr();

        run(5, 4'b0000, 4'b0101, 0, 1, 0);
        want = '{S_FETCH, S_DECODE, S_RTYPE, S_WRITE, S_PCUP};
        chk_trace("rtype_trace");
        chk_bits("rtype_wr", tr_wr, 'h08);
        chk("rtype_back", int'(state_o), int'(S_FETCH));
        clr();

        run(2, 4'b0100, 4'b0000, 0, 1, 0);
        run(3, 4'b0100, 4'b0000, 0, 0, 0);
        run(3, 4'b0100, 4'b0000, 0, 1, 0);
        want = '{S_FETCH, S_DECODE, S_LBM, S_LBM, S_LBM, S_LBM, S_LBL, S_PCUP};
        chk_trace("load_trace");
        chk_bits("load_mre", tr_mre, 'h20);
        chk_bits("load_wr", tr_wr, 'h40);
        clr();

        run(9, 4'b0000, 4'b0000, 0, 1, 0);
        want = '{S_FETCH, S_DECODE, S_RTYPE, S_WAIT, S_WAIT, S_WAIT,
                 S_WAIT, S_WAIT, S_PCUP};
        chk_trace("wait_trace");
        chk("wait_back", int'(state_o), int'(S_FETCH));
        clr();

        run(5, 4'b0001, 4'b0000, 0, 1, 1);
`ifdef MC_SEQ_IRQ_EN
        chk("irq_save", int'(state_o), int'(S_ISAVE));
        chk("irq_epc", int'(epc_en), 1);
        run(2, 4'b0001, 4'b0000, 0, 1, 0);
        want = '{S_FETCH, S_DECODE, S_ITYPE, S_WRITE, S_PCUP, S_ISAVE, S_IVEC};
`else
        want = '{S_FETCH, S_DECODE, S_ITYPE, S_WRITE, S_PCUP};
`endif
        chk_trace("addi_irq_trace");
        chk("addi_back", int'(state_o), int'(S_FETCH));
        clr();

        run(2, 4'b0100, 4'b0100, 0, 1, 0);
        run(1, 4'b0100, 4'b0100, 0, 0, 0);
        run(2, 4'b0100, 4'b0100, 0, 1, 0);
        run(5, 4'b0111, 4'b0000, 0, 1, 0);
        run(3, 4'b1100, 4'b0000, 1, 1, 0);
        run(3, 4'b1100, 4'b0000, 0, 1, 0);
        run(3, 4'b0100, 4'b1100, 1, 1, 0);
        run(4, 4'b0100, 4'b1000, 0, 1, 0);
        want = '{S_FETCH, S_DECODE, S_SBR, S_SBR, S_PCUP,
                 S_FETCH, S_DECODE, S_ITYPE, S_SBI, S_PCUP,
                 S_FETCH, S_DECODE, S_CD, S_FETCH, S_DECODE, S_PCUP,
                 S_FETCH, S_DECODE, S_JUMP, S_FETCH, S_DECODE, S_CR, S_WRJ};
        chk_trace("misc_trace");
        clr();

        run(5, 4'b1000, 4'b0100, 0, 1, 0);
        run(4, 4'b1011, 4'b0000, 0, 1, 0);
        run(4, 4'b0000, 4'b1011, 0, 1, 0);
        want = '{S_FETCH, S_DECODE, S_RTYPE, S_WRITE, S_PCUP,
                 S_FETCH, S_DECODE, S_ITYPE, S_PCUP,
                 S_FETCH, S_DECODE, S_RTYPE, S_PCUP};
        chk_trace("alt_trace");
        clr();

        run(3, 4'b0000, 4'b0101, 0, 0, 0);
        run(1, 4'b0000, 4'b0101, 0, 1, 0);
        chk("stall3_ok", int'(state_o), int'(S_DECODE));
        run(4, 4'b0000, 4'b0101, 0, 1, 0);

        run(4, 4'b0000, 4'b0000, 0, 0, 0);
        chk("tmo_state", int'(state_o), int'(S_FAULT));
        chk("tmo_fault", int'(fault), 1);
        run(100, 4'b0000, 4'b0000, 0, 1, 0);
        chk("tmo_hold", int'(state_o), int'(S_FAULT));
        do_reset();
        chk("tmo_reset", int'(state_o), int'(S_FETCH));

        run(2, 4'b0100, 4'b0010, 0, 1, 0);
        chk("illegal", int'(state_o), int'(S_FAULT));
        do_reset();

        run(2, 4'b0100, 4'b0100, 0, 1, 0);
        mem_ready = 1'b0;
        #1;
        chk("sb_wr", int'(mem_wr), 1);
        reset = 1'b1;
        #1;
        chk("sb_rst_wr", int'(mem_wr), 0);
        chk("sb_rst_st", int'(state_o), int'(S_FETCH));
        @(posedge clk);
        #1;
        reset = 1'b0;
        clr();
        run(5, 4'b0000, 4'b0101, 0, 1, 0);
        want = '{S_FETCH, S_DECODE, S_RTYPE, S_WRITE, S_PCUP};
        chk_trace("recover_trace");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mc_sequencer.md
MC_SEQUENCER -- requirements
Module: mc_sequencer

Interface
REQ-001 Parameter WAIT_CYCLES, default 8388607: number of clocks the WAIT state occupies; legal values are 1 or greater.
REQ-002 Parameter WAIT_W, default 24: width of the wait counter; must satisfy 2^WAIT_W > WAIT_CYCLES.
REQ-003 Parameter MEM_TIMEOUT, default 15: maximum number of stalled memory cycles; 0 disables the timeout.
REQ-004 Ports (name, direction, width, meaning):
- clk, in, 1: the single clock; all state is on the rising edge.
- reset, in, 1: asynchronous reset, active-high.
- op, op_ext, in, 4 each: instruction opcode and opcode extension fields.
- branch_taken, in, 1: pre-evaluated branch/jump condition.
- mem_ready, in, 1: memory completes the current access in this cycle.
- irq, in, 1: level interrupt request.
- wd_s, alua_s, alub_s, mem_s, out, 2 each: datapath mux selects.
- mem_data_s, pc_s, pc_en, reg_wr_en, instr_en, alu_out_en, mem_reg_en, mem_wr, se_sign, psr_en, out, 1 each: datapath controls.
- mem_req, out, 1: a memory access is pending.
- fault, out, 1: the sequencer is halted in FAULT.
- irq_ack, epc_en, vec_s, out, 1 each: interrupt acknowledge, capture PC into the EPC register, select the vector address into the PC.
- state_o, out, 5: current state encoding, for debug.

Function
REQ-005 States: FETCH, DECODE, RTYPE_EX, ITYPE_EX, WRITE, LB_MEM, LB_LOAD, SB_MEM_R, SB_MEM_I, CALC_DISP, JUMP, CALC_RLINK, WR_RLINK_J, PC_UP, WAIT, FAULT, IRQ_SAVE, IRQ_VEC.
REQ-006 Outputs are decoded from the current state only, except instr_en and mem_reg_en, which are also gated by mem_ready.
REQ-007 Default for every output is 0, with two exceptions: se_sign defaults to 1, and state_o always shows the current state.
REQ-008 FETCH:
- Drives mem_s=01 and mem_req=1.
- Drives instr_en=mem_ready.
- Moves to DECODE on mem_ready=1; otherwise holds.
REQ-009 DECODE transitions:
- op=0100 with op_ext=0100 -> SB_MEM_R.
- op=0100 with op_ext=0000 -> LB_MEM.
- op=0100 with op_ext=1100 -> JUMP if branch_taken, else PC_UP.
- op=0100 with op_ext=1000 -> CALC_RLINK.
- op=0100 with any other op_ext -> FAULT.
- op=0000 -> RTYPE_EX.
- op=1000 -> RTYPE_EX if op_ext=0100, else ITYPE_EX.
- op=1100 -> CALC_DISP if branch_taken, else PC_UP.
- Any other op -> ITYPE_EX.
REQ-010 RTYPE_EX:
- Drives alu_out_en=1 and psr_en=1.
- Next state: op_ext=1011 -> PC_UP; op_ext=0000 -> WAIT; otherwise WRITE.
REQ-011 ITYPE_EX:
- Drives alua_s=10, alu_out_en=1, psr_en=1.
- Drives se_sign=0 for op 0001, 0010 or 0011.
- Next state: op=1011 -> PC_UP; op=0111 -> SB_MEM_I; otherwise WRITE.
REQ-012 WRITE drives wd_s=11 and reg_wr_en=1, then moves to PC_UP.
REQ-013 LB_MEM:
- Drives wd_s=10, mem_req=1, mem_reg_en=mem_ready.
- Holds until mem_ready, then moves to LB_LOAD.
REQ-014 LB_LOAD drives wd_s=10 and reg_wr_en=1, then moves to PC_UP.
REQ-015 SB_MEM_R drives mem_wr=1 and mem_req=1; SB_MEM_I drives mem_s=10, mem_wr=1, mem_data_s=1 and mem_req=1.
REQ-016 SB_MEM_R and SB_MEM_I each hold until mem_ready, then move to PC_UP.
REQ-017 CALC_DISP drives alua_s=01, alub_s=01, pc_s=1, pc_en=1, then moves to FETCH.
REQ-018 JUMP drives pc_en=1, then moves to FETCH.
REQ-019 CALC_RLINK drives alua_s=01, alub_s=10, alu_out_en=1, then moves to WR_RLINK_J.
REQ-020 WR_RLINK_J drives wd_s=11, reg_wr_en=1, pc_en=1, then moves to FETCH.
REQ-021 PC_UP drives alua_s=01, alub_s=10, pc_s=1, pc_en=1, then moves to FETCH (or IRQ_SAVE per REQ-028).
REQ-022 WAIT counter:
- Clears on every cycle outside WAIT.
- Increments each cycle in WAIT.
- WAIT lasts exactly WAIT_CYCLES clocks, then moves to PC_UP.
REQ-023 Stall counter:
- Increments each cycle in which mem_req=1 and mem_ready=0.
- Clears when mem_ready=1 or when leaving a memory state.
- When MEM_TIMEOUT is nonzero and the count reaches MEM_TIMEOUT, the next state is FAULT.
- A mem_ready on the same cycle the count reaches MEM_TIMEOUT wins: the access completes normally.
REQ-024 FAULT drives fault=1 and all other controls 0; it is exited only by reset.

Reset
REQ-025 Asserting reset immediately forces state=FETCH, clears the wait and stall counters, and aborts any access in progress.
REQ-026 While reset is high, all outputs are 0 except se_sign=1, mem_s=01 and state_o=FETCH; mem_req and instr_en are forced to 0.
REQ-027 On the first clock after reset deasserts, FETCH begins normally with mem_req=1.

Configuration
REQ-028 Macro MC_SEQ_IRQ_EN defined:
- In PC_UP with irq=1, the next state is IRQ_SAVE instead of FETCH.
- IRQ_SAVE drives epc_en=1 and irq_ack=1, then moves to IRQ_VEC.
- IRQ_VEC drives vec_s=1 and pc_en=1, then moves to FETCH.
- irq is sampled only in PC_UP, so at least one instruction executes between interrupts.
REQ-029 Macro MC_SEQ_IRQ_EN undefined: irq is ignored, irq_ack, epc_en and vec_s are tied to 0, and IRQ_SAVE and IRQ_VEC are unreachable.

Verification
REQ-030 Instruction op=0000, op_ext=0101, mem_ready=1 -> states FETCH, DECODE, RTYPE_EX, WRITE, PC_UP, FETCH; reg_wr_en=1 only in WRITE.
REQ-031 Load: op=0100, op_ext=0000, mem_ready held low for 3 cycles in LB_MEM -> 4 cycles in LB_MEM; mem_reg_en=1 only in the last of them; then LB_LOAD.
REQ-032 MEM_TIMEOUT=4, mem_ready stuck at 0 in FETCH -> FAULT entered after 4 stalled cycles; fault=1; still in FAULT 100 cycles later; reset returns the sequencer to FETCH.
REQ-033 WAIT_CYCLES=5, op=0000, op_ext=0000 -> exactly 5 cycles in WAIT, then PC_UP.
REQ-034 With MC_SEQ_IRQ_EN defined, irq=1 during an ADDI -> PC_UP, IRQ_SAVE (epc_en=1), IRQ_VEC (vec_s=1, pc_en=1), FETCH; without the macro -> PC_UP, FETCH.
REQ-035 Reset asserted mid-SB_MEM_R -> mem_wr drops to 0 in the same cycle and state_o=FETCH.
